// File: rtl/wb_result_arbiter_if.sv
// Bundle of the per-channel result handshakes and the registered writeback port.
// The slave modport is the arbiter's view; the master modport drives results and wb_ready.
interface wb_result_arbiter_if #(
    parameter int N      = 16,
    parameter int NUM_CH = 8,
    parameter int RD_W   = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]      in_valid;
    logic [NUM_CH-1:0]      in_ready;
    logic [NUM_CH*N-1:0]    in_data;
    logic [NUM_CH*RD_W-1:0] in_rd;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [N-1:0]           wb_data;
    logic [RD_W-1:0]        wb_rd;
    logic [CH_W-1:0]        wb_ch;
    logic                   busy;

    modport master (
        output in_valid, in_data, in_rd, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_rd, wb_ch, busy
    );

    modport slave (
        input  in_valid, in_data, in_rd, wb_ready,
        output in_ready, wb_valid, wb_data, wb_rd, wb_ch, busy
    );
endinterface

// File: rtl/wb_result_arbiter.sv
// Writeback selector: each execution unit parks its result in a one-entry slot,
// and a round-robin arbiter drains the slots into a registered writeback port.
module wb_result_arbiter #(
    parameter int N      = 16,
    parameter int NUM_CH = 8,
    parameter int RD_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_result_arbiter_if.slave   bus
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] accept;
    logic [N-1:0]      slot_data [NUM_CH];
    logic [RD_W-1:0]   slot_rd   [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   scan_idx;
    int                scan_pos;
    logic              grant_any;
    logic              out_load;

    logic              wb_valid_q;
    logic [N-1:0]      wb_data_q;
    logic [RD_W-1:0]   wb_rd_q;
    logic [CH_W-1:0]   wb_ch_q;

    assign out_load = !wb_valid_q || bus.wb_ready;
    assign accept   = bus.in_valid & bus.in_ready;

    // First full slot at or above rr_ptr, wrapping; independent of in_valid so no loop through in_ready.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        scan_pos  = 0;
        scan_idx  = '0;
        if (out_load) begin
            for (int k = 0; k < NUM_CH; k++) begin
                scan_pos = int'(rr_ptr) + k;
                if (scan_pos >= NUM_CH) begin
                    scan_pos = scan_pos - NUM_CH;
                end
                scan_idx = CH_W'(scan_pos);
                if (!grant_any && full[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A refill in the same cycle as the grant wins, so full stays set with the new result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot_data[i] <= '0;
                slot_rd[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i]) begin
                    slot_data[i] <= bus.in_data[i*N +: N];
                    slot_rd[i]   <= bus.in_rd[i*RD_W +: RD_W];
                    full[i]      <= 1'b1;
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_ch_q    <= '0;
            rr_ptr     <= '0;
        end else if (grant_any) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= slot_data[grant_idx];
            wb_rd_q    <= slot_rd[grant_idx];
            wb_ch_q    <= grant_idx;
            rr_ptr     <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end else if (out_load) begin
            wb_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready = ~full | grant;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_ch    = wb_ch_q;
    assign bus.busy     = (|full) || wb_valid_q;
endmodule

// File: tb/tb_wb_result_arbiter.sv
// Scoreboarded bench for wb_result_arbiter: directed traffic feeds per-channel
// expectation queues, and a negedge monitor checks every writeback transfer.
module tb_wb_result_arbiter;
    localparam int N      = 16;
    localparam int NUM_CH = 8;
    localparam int RD_W   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [N+RD_W-1:0] ch_q [NUM_CH][$];
    int                order_q[$];
    bit                sat_active = 1'b0;
    int                sat_seen   = 0;
    int                ch_count [NUM_CH];
    int                seq      [NUM_CH];
    int                mon_ch;
    logic [N+RD_W-1:0] mon_exp;

    wb_result_arbiter_if #(.N(N), .NUM_CH(NUM_CH), .RD_W(RD_W)) bus ();

    wb_result_arbiter #(.N(N), .NUM_CH(NUM_CH), .RD_W(RD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] valid, input logic ready);
        @(posedge clk);
        #1;
        bus.in_valid = valid;
        bus.wb_ready = ready;
    endtask

    task automatic setChannel(input int ch, input logic [N-1:0] data, input logic [RD_W-1:0] rd);
        bus.in_data[ch*N +: N]       = data;
        bus.in_rd[ch*RD_W +: RD_W]   = rd;
    endtask

    task automatic flushScoreboard();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_q[i].delete();
        end
        order_q.delete();
    endtask

    task automatic waitIdle(input string name, input int max_cycles);
        int c;
        c = 0;
        while (bus.busy && c < max_cycles) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput(name, {31'd0, bus.busy}, 32'd0);
    endtask

    // Pop before push: a result accepted this cycle cannot already be on the writeback port.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wb_valid && bus.wb_ready) begin
                mon_ch = int'(bus.wb_ch);
                if (ch_q[mon_ch].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL sb_unexpected: got ch %0d data %h, want no output", mon_ch, bus.wb_data);
                end else begin
                    mon_exp = ch_q[mon_ch].pop_front();
                    checkOutput("sb_data", {16'd0, bus.wb_data}, {16'd0, mon_exp[N+RD_W-1:RD_W]});
                    checkOutput("sb_rd", {28'd0, bus.wb_rd}, {28'd0, mon_exp[RD_W-1:0]});
                end
                if (order_q.size() > 0) begin
                    checkOutput("sb_order", {29'd0, bus.wb_ch}, order_q.pop_front());
                end
                if (sat_active && sat_seen < 64) begin
                    ch_count[mon_ch]++;
                    sat_seen++;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.in_valid[i] && bus.in_ready[i]) begin
                    ch_q[i].push_back({bus.in_data[i*N +: N], bus.in_rd[i*RD_W +: RD_W]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.in_rd    = '0;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_count[i] = 0;
            seq[i]      = 0;
        end

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_wb_data", {16'd0, bus.wb_data}, 32'd0);
        checkOutput("rst_wb_rd", {28'd0, bus.wb_rd}, 32'd0);
        checkOutput("rst_wb_ch", {29'd0, bus.wb_ch}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", {24'd0, bus.in_ready}, 32'h0000_00FF);

        // Single result on ch2: accepted at edge t, visible for one cycle after edge t+1
        $display("[TB] single result");
        applyStimulus(8'h04, 1'b1);
        setChannel(2, 16'h1234, 4'd5);
        order_q.push_back(2);
        applyStimulus(8'h00, 1'b1);
        checkOutput("single_early", {31'd0, bus.wb_valid}, 32'd0);
        applyStimulus(8'h00, 1'b1);
        checkOutput("single_valid", {31'd0, bus.wb_valid}, 32'd1);
        checkOutput("single_data", {16'd0, bus.wb_data}, 32'h0000_1234);
        checkOutput("single_rd", {28'd0, bus.wb_rd}, 32'd5);
        checkOutput("single_ch", {29'd0, bus.wb_ch}, 32'd2);
        applyStimulus(8'h00, 1'b1);
        checkOutput("single_once", {31'd0, bus.wb_valid}, 32'd0);
        checkOutput("single_left", order_q.size(), 32'd0);

        // Reset while one result is stalled on the port and another is in a slot
        $display("[TB] reset mid-traffic");
        applyStimulus(8'h22, 1'b0);
        setChannel(1, 16'hDEAD, 4'hA);
        setChannel(5, 16'hBEEF, 4'hB);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("midrst_pre_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        flushScoreboard();
        #1;
        checkOutput("midrst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midrst_wb_data", {16'd0, bus.wb_data}, 32'd0);
        checkOutput("midrst_wb_ch", {29'd0, bus.wb_ch}, 32'd0);
        repeat (2) applyStimulus(8'h00, 1'b1);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_in_ready", {24'd0, bus.in_ready}, 32'h0000_00FF);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(8'h00, 1'b1);
            checkOutput("midrst_stale", {31'd0, bus.wb_valid}, 32'd0);
        end

        // Round-robin from rr_ptr=0; ch0 refills on its own grant, ch3 retries after its grant
        $display("[TB] round-robin");
        applyStimulus(8'h89, 1'b1);
        setChannel(0, 16'h00A0, 4'd1);
        setChannel(3, 16'h03A3, 4'd2);
        setChannel(7, 16'h07A7, 4'd3);
        order_q = '{0, 3, 7, 0, 3};
        applyStimulus(8'h09, 1'b1);
        setChannel(0, 16'h00B1, 4'd4);
        setChannel(3, 16'h03B1, 4'd6);
        checkOutput("rr_idle", {31'd0, bus.wb_valid}, 32'd0);
        applyStimulus(8'h08, 1'b1);
        checkOutput("rr_ch_1st", {29'd0, bus.wb_ch}, 32'd0);
        checkOutput("rr_data_1st", {16'd0, bus.wb_data}, 32'h0000_00A0);
        checkOutput("rr_ready3", {31'd0, bus.in_ready[3]}, 32'd1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("rr_ch_2nd", {29'd0, bus.wb_ch}, 32'd3);
        checkOutput("rr_data_2nd", {16'd0, bus.wb_data}, 32'h0000_03A3);
        applyStimulus(8'h00, 1'b1);
        checkOutput("rr_ch_3rd", {29'd0, bus.wb_ch}, 32'd7);
        checkOutput("rr_data_3rd", {16'd0, bus.wb_data}, 32'h0000_07A7);
        applyStimulus(8'h00, 1'b1);
        checkOutput("rr_ch_4th", {29'd0, bus.wb_ch}, 32'd0);
        checkOutput("rr_data_4th", {16'd0, bus.wb_data}, 32'h0000_00B1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("rr_ch_5th", {29'd0, bus.wb_ch}, 32'd3);
        checkOutput("rr_data_5th", {16'd0, bus.wb_data}, 32'h0000_03B1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("rr_done", {31'd0, bus.wb_valid}, 32'd0);
        checkOutput("rr_left", order_q.size(), 32'd0);

        // Back-pressure: ch2 stalls on the port while ch1 and ch4 wait in their slots
        $display("[TB] back-pressure");
        applyStimulus(8'h04, 1'b0);
        setChannel(2, 16'h2222, 4'd7);
        applyStimulus(8'h12, 1'b0);
        setChannel(1, 16'h1111, 4'd8);
        setChannel(4, 16'h4444, 4'd9);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(8'h00, 1'b0);
            checkOutput("bp_valid", {31'd0, bus.wb_valid}, 32'd1);
            checkOutput("bp_data", {16'd0, bus.wb_data}, 32'h0000_2222);
            checkOutput("bp_rd", {28'd0, bus.wb_rd}, 32'd7);
            checkOutput("bp_ch", {29'd0, bus.wb_ch}, 32'd2);
            checkOutput("bp_ready1", {31'd0, bus.in_ready[1]}, 32'd0);
            checkOutput("bp_ready4", {31'd0, bus.in_ready[4]}, 32'd0);
        end
        order_q = '{2, 4, 1};
        applyStimulus(8'h00, 1'b1);
        waitIdle("bp_drain", 10);
        checkOutput("bp_left", order_q.size(), 32'd0);

        // Streaming: ch6 alone sustains one result per cycle
        $display("[TB] streaming");
        for (int k = 0; k < 12; k++) begin
            applyStimulus((k < 10) ? 8'h40 : 8'h00, 1'b1);
            if (k < 10) begin
                setChannel(6, 16'(k), 4'(k));
                checkOutput("stream_ready6", {31'd0, bus.in_ready[6]}, 32'd1);
            end
            if (k >= 2) begin
                checkOutput("stream_valid", {31'd0, bus.wb_valid}, 32'd1);
                checkOutput("stream_data", {16'd0, bus.wb_data}, 32'(k - 2));
            end
        end
        applyStimulus(8'h00, 1'b1);
        checkOutput("stream_end", {31'd0, bus.wb_valid}, 32'd0);

        // Saturation: every channel requests every cycle for 64 cycles
        $display("[TB] saturation");
        sat_active = 1'b1;
        sat_seen   = 0;
        for (int c = 0; c < 64; c++) begin
            applyStimulus(8'hFF, 1'b1);
            for (int i = 0; i < NUM_CH; i++) begin
                setChannel(i, {4'(i), 12'(seq[i])}, 4'(i));
            end
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.in_ready[i]) begin
                    seq[i]++;
                end
            end
        end
        applyStimulus(8'h00, 1'b1);
        waitIdle("sat_drain", 40);
        sat_active = 1'b0;
        checkOutput("sat_seen", sat_seen, 32'd64);
        for (int i = 0; i < NUM_CH; i++) begin
            checkOutput("sat_grants", ch_count[i], 32'd8);
        end

        for (int i = 0; i < NUM_CH; i++) begin
            checkOutput("sb_leftover", ch_q[i].size(), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
